// File: rtl/izh_pkg.sv
// Shared fixed-point format, reset constants and scheduler state encoding
// for the time-multiplexed Izhikevich neuron array.
package izh_pkg;

   localparam int DATA_W = 17;
   localparam int FRAC_W = 8;

   localparam logic signed [DATA_W-1:0] V_RESET = -17'sd16640;
   localparam logic signed [DATA_W-1:0] U_RESET = -17'sd3328;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_ISSUE,
      ST_WAIT,
      ST_WRITE,
      ST_DONE
   } sched_state_t;

endpackage

// File: rtl/neuron_scheduler_if.sv
// Request/response link between the neuron scheduler (master) and the
// shared single-neuron Izhikevich update core (slave).
interface neuron_scheduler_if #(
   parameter int DATA_W = 17
);

   logic              core_req;
   logic [DATA_W-1:0] core_v;
   logic [DATA_W-1:0] core_u;
   logic [DATA_W-1:0] core_i;
   logic              core_ack;
   logic [DATA_W-1:0] core_v_res;
   logic [DATA_W-1:0] core_u_res;
   logic              core_fired;

   modport master (
      output core_req, core_v, core_u, core_i,
      input  core_ack, core_v_res, core_u_res, core_fired
   );

   modport slave (
      input  core_req, core_v, core_u, core_i,
      output core_ack, core_v_res, core_u_res, core_fired
   );

endinterface

// File: rtl/neuron_state_mem.sv
// Per-neuron v/u/i register file: one decoded write port (v/u or i lane)
// and a registered read port. All entries return to resting values on reset.
module neuron_state_mem
   import izh_pkg::*;
#(
   parameter int N_NEURONS = 8,
   parameter int ADDR_W    = 3,
   parameter int DATA_W    = izh_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              syn_reset,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              wr_vu_en,
   input  logic [DATA_W-1:0] wr_v,
   input  logic [DATA_W-1:0] wr_u,
   input  logic              wr_i_en,
   input  logic [DATA_W-1:0] wr_i,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_v,
   output logic [DATA_W-1:0] rd_u,
   output logic [DATA_W-1:0] rd_i
);

   logic [DATA_W-1:0] v_mem [N_NEURONS];
   logic [DATA_W-1:0] u_mem [N_NEURONS];
   logic [DATA_W-1:0] i_mem [N_NEURONS];

   always_ff @(posedge clk) begin
      if (syn_reset) begin
         for (int n = 0; n < N_NEURONS; n++) begin
            v_mem[n] <= DATA_W'(V_RESET);
            u_mem[n] <= DATA_W'(U_RESET);
            i_mem[n] <= '0;
         end
         rd_v <= '0;
         rd_u <= '0;
         rd_i <= '0;
      end else begin
         for (int n = 0; n < N_NEURONS; n++) begin
            if (wr_vu_en && (wr_addr == ADDR_W'(n))) begin
               v_mem[n] <= wr_v;
               u_mem[n] <= wr_u;
            end
            if (wr_i_en && (wr_addr == ADDR_W'(n))) begin
               i_mem[n] <= wr_i;
            end
         end
         if (rd_en) begin
            rd_v <= v_mem[rd_addr];
            rd_u <= u_mem[rd_addr];
            rd_i <= i_mem[rd_addr];
         end
      end
   end

endmodule

// File: rtl/neuron_scheduler.sv
// Sweeps all neurons through one shared update core per timestep, writing
// results back verbatim and reporting spikes.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | accept current loads; wait for step_start
//   ST_READ  | registered read of v/u/i at addr
//   ST_ISSUE | one-cycle core_req with operands
//   ST_WAIT  | hold until core_ack, capture results
//   ST_WRITE | write v/u back, report spike, advance or finish
//   ST_DONE  | step_done pulse
module neuron_scheduler
   import izh_pkg::*;
#(
   parameter int N_NEURONS = 8,
   parameter int ADDR_W    = 3,
   parameter int DATA_W    = izh_pkg::DATA_W,
   parameter int FRAC_W    = izh_pkg::FRAC_W
) (
   input  logic                  clk,
   input  logic                  syn_reset,
   input  logic                  step_start,
   input  logic                  i_wr_en,
   input  logic [ADDR_W-1:0]     i_wr_addr,
   input  logic [DATA_W-1:0]     i_wr_data,
   output logic                  i_wr_ready,
   output logic                  busy,
   output logic                  step_done,
   output logic                  spike_valid,
   output logic [ADDR_W-1:0]     spike_addr,
   neuron_scheduler_if.master    core
);

   if (N_NEURONS < 2 || ADDR_W != $clog2(N_NEURONS) || FRAC_W >= DATA_W) begin : g_bad_params
      $error("neuron_scheduler: inconsistent N_NEURONS/ADDR_W/FRAC_W");
   end

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_NEURONS - 1);

   sched_state_t      state, state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] res_v, res_u;
   logic              res_fired;

   logic              rd_en, wr_vu_en, wr_i_en;
   logic [ADDR_W-1:0] mem_wr_addr;
   logic [DATA_W-1:0] rd_v, rd_u, rd_i;

   always_ff @(posedge clk) begin
      if (syn_reset) begin
         state     <= ST_IDLE;
         addr      <= '0;
         res_v     <= '0;
         res_u     <= '0;
         res_fired <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_WAIT && core.core_ack) begin
            res_v     <= core.core_v_res;
            res_u     <= core.core_u_res;
            res_fired <= core.core_fired;
         end
         if (state == ST_WRITE && addr != LAST_ADDR) begin
            addr <= addr + ADDR_W'(1);
         end else if (state == ST_DONE) begin
            addr <= '0;
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      i_wr_ready    = 1'b0;
      step_done     = 1'b0;
      spike_valid   = 1'b0;
      core.core_req = 1'b0;
      rd_en         = 1'b0;
      wr_vu_en      = 1'b0;
      case (state)
         ST_IDLE: begin
            i_wr_ready = 1'b1;
            if (step_start) state_nxt = ST_READ;
         end
         ST_READ: begin
            rd_en     = 1'b1;
            state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            core.core_req = 1'b1;
            state_nxt     = ST_WAIT;
         end
         ST_WAIT: begin
            if (core.core_ack) state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            wr_vu_en    = 1'b1;
            spike_valid = res_fired;
            state_nxt   = (addr == LAST_ADDR) ? ST_DONE : ST_READ;
         end
         ST_DONE: begin
            step_done = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Host loads and sweep write-backs never overlap, so they share one port.
   assign wr_i_en     = i_wr_en && (state == ST_IDLE);
   assign mem_wr_addr = (state == ST_IDLE) ? i_wr_addr : addr;

   neuron_state_mem #(
      .N_NEURONS (N_NEURONS),
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W)
   ) u_mem (
      .clk       (clk),
      .syn_reset (syn_reset),
      .wr_addr   (mem_wr_addr),
      .wr_vu_en  (wr_vu_en),
      .wr_v      (res_v),
      .wr_u      (res_u),
      .wr_i_en   (wr_i_en),
      .wr_i      (i_wr_data),
      .rd_en     (rd_en),
      .rd_addr   (addr),
      .rd_v      (rd_v),
      .rd_u      (rd_u),
      .rd_i      (rd_i)
   );

   assign core.core_v = rd_v;
   assign core.core_u = rd_u;
   assign core.core_i = rd_i;
   assign busy        = (state != ST_IDLE);
   assign spike_addr  = addr;

endmodule

// File: tb/tb_neuron_scheduler.sv
// Bench for neuron_scheduler: a latency-programmable core model plus a
// timestep-level reference model checked against the DUT every cycle.
module tb_neuron_scheduler;

   localparam int N  = 8;
   localparam int AW = 3;
   localparam int DW = 17;

   logic          clk = 1'b0;
   logic          syn_reset = 1'b1;
   logic          step_start = 1'b0;
   logic          i_wr_en = 1'b0;
   logic [AW-1:0] i_wr_addr = '0;
   logic [DW-1:0] i_wr_data = '0;
   logic          i_wr_ready, busy, step_done, spike_valid;
   logic [AW-1:0] spike_addr;

   neuron_scheduler_if #(.DATA_W(DW)) core_bus ();

   neuron_scheduler #(
      .N_NEURONS (N),
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .FRAC_W    (8)
   ) dut (
      .clk         (clk),
      .syn_reset   (syn_reset),
      .step_start  (step_start),
      .i_wr_en     (i_wr_en),
      .i_wr_addr   (i_wr_addr),
      .i_wr_data   (i_wr_data),
      .i_wr_ready  (i_wr_ready),
      .busy        (busy),
      .step_done   (step_done),
      .spike_valid (spike_valid),
      .spike_addr  (spike_addr),
      .core        (core_bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [31:0] z17(input logic [16:0] x);
      return {15'b0, x};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Core model: v+1.0+i (input current drives the membrane), u-1.0,
   // fired when v_res > 0. Latency 2, or 10 for one flagged request,
   // optionally with a bogus ack in the request cycle itself.
   int                   cur_lat = 2;
   bit                   slow_next = 0, early_next = 0;
   bit                   pend = 0;
   int                   ack_at = 0;
   logic signed [DW-1:0] pv, pu;
   logic                 pf;

   initial begin
      core_bus.core_ack   = 1'b0;
      core_bus.core_v_res = '0;
      core_bus.core_u_res = '0;
      core_bus.core_fired = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         core_bus.core_ack = 1'b0;
         if (pend && cyc == ack_at) begin
            core_bus.core_ack   = 1'b1;
            core_bus.core_v_res = pv;
            core_bus.core_u_res = pu;
            core_bus.core_fired = pf;
            pend = 0;
         end
         if (core_bus.core_req) begin
            cur_lat   = slow_next ? 10 : 2;
            slow_next = 0;
            pv   = core_bus.core_v + 17'd256 + core_bus.core_i;
            pu   = core_bus.core_u - 17'd256;
            pf   = (pv > 0);
            pend = 1;
            ack_at = cyc + cur_lat;
            if (early_next) begin
               early_next = 0;
               core_bus.core_ack   = 1'b1;
               core_bus.core_v_res = 17'h0AAAA;
               core_bus.core_u_res = 17'h05555;
               core_bus.core_fired = 1'b1;
            end
         end
      end
   end

   // Reference model: neuron contents and sweep timing in plain arithmetic.
   typedef struct { int at; int addr; } spk_t;
   logic signed [DW-1:0] mv [N], mu [N], mi [N];
   spk_t spk_q [$];
   bit   chk_on = 0, in_sweep = 0;
   int   busy_from = 0, exp_done = -1, exp_req_at = -1, exp_addr = 0;
   logic [DW-1:0] obs_v [N], obs_i [N];
   int   spike_cnt = 0, spike_seen_addr = -1, spike_at = -1, req_cnt = 0;

   task automatic model_reset();
      for (int n = 0; n < N; n++) begin
         mv[n] = -17'sd16640;
         mu[n] = -17'sd3328;
         mi[n] = '0;
      end
      in_sweep = 0;
      exp_done = -1;
      exp_req_at = -1;
      spk_q.delete();
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         bit exp_busy, exp_req;
         logic signed [DW-1:0] nv;
         int a;
         exp_busy = in_sweep && cyc >= busy_from && (exp_done < 0 || cyc <= exp_done);
         exp_req  = in_sweep && cyc == exp_req_at;
         chk("busy", busy, exp_busy);
         chk("i_wr_ready", i_wr_ready, !exp_busy);
         chk("step_done", step_done, in_sweep && cyc == exp_done);
         chk("core_req", core_bus.core_req, exp_req);
         if (core_bus.core_req) req_cnt++;
         if (exp_req) begin
            a = exp_addr;
            chk("core_v", z17(core_bus.core_v), z17(mv[a]));
            chk("core_u", z17(core_bus.core_u), z17(mu[a]));
            chk("core_i", z17(core_bus.core_i), z17(mi[a]));
            obs_v[a] = core_bus.core_v;
            obs_i[a] = core_bus.core_i;
            nv    = mv[a] + 17'sd256 + mi[a];
            mv[a] = nv;
            mu[a] = mu[a] - 17'sd256;
            if (nv > 0) spk_q.push_back('{at: cyc + cur_lat + 1, addr: a});
            if (a == N - 1) exp_done = cyc + cur_lat + 2;
            else            exp_req_at = cyc + cur_lat + 3;
            exp_addr++;
         end
         if (spk_q.size() > 0 && spk_q[0].at == cyc) begin
            chk("spike_valid", spike_valid, 1);
            chk("spike_addr", spike_addr, spk_q[0].addr);
            void'(spk_q.pop_front());
         end else begin
            chk("spike_valid", spike_valid, 0);
         end
         if (spike_valid) begin
            spike_cnt++;
            spike_seen_addr = spike_addr;
            spike_at = cyc;
         end
         if (syn_reset) begin
            model_reset();
         end else if (!in_sweep) begin
            if (i_wr_en) mi[i_wr_addr] = i_wr_data;
            if (step_start) begin
               in_sweep   = 1;
               busy_from  = cyc + 1;
               exp_done   = -1;
               exp_req_at = cyc + 2;
               exp_addr   = 0;
            end
         end else if (exp_done >= 0 && cyc == exp_done) begin
            in_sweep = 0;
         end
      end
   end

   int start_cyc = 0, done_off = -1;

   task automatic write_i(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(posedge clk); #2;
      i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
      @(posedge clk); #2;
      i_wr_en = 1'b0;
   endtask

   task automatic run_step(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input bit poke);
      spike_cnt = 0; spike_seen_addr = -1; spike_at = -1; req_cnt = 0; done_off = -1;
      @(posedge clk); #2;
      start_cyc  = cyc;
      step_start = 1'b1;
      if (wr) begin
         i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
      end
      for (int t = 1; t < 200; t++) begin
         @(posedge clk); #2;
         step_start = 1'b0;
         i_wr_en    = 1'b0;
         if (poke && (t == 5 || t == 20 || t == 40)) step_start = 1'b1;
         if (poke && (t == 10 || t == 30)) begin
            i_wr_en = 1'b1; i_wr_addr = 3'd0; i_wr_data = 17'd1234;
         end
         if (step_done) begin
            done_off = cyc - start_cyc;
            break;
         end
      end
      @(posedge clk); #2;
      step_start = 1'b0;
      i_wr_en    = 1'b0;
   endtask

   initial begin
      int cnt;
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      syn_reset = 1'b0;
      chk("reset busy", busy, 0);
      chk("reset i_wr_ready", i_wr_ready, 1);
      chk("reset core_req", core_bus.core_req, 0);
      chk("reset core_v", z17(core_bus.core_v), 0);
      chk("reset spike_addr", spike_addr, 0);
      chk("reset step_done", step_done, 0);
      chk_on = 1;

      // A: plain sweep from reset.
      run_step(0, '0, '0, 0);
      chk("A done offset", done_off, 41);
      chk("A spikes", spike_cnt, 0);
      chk("A core_v[0]", z17(obs_v[0]), z17(-17'sd16640));
      chk("A core_v[7]", z17(obs_v[7]), z17(-17'sd16640));
      chk("A req count", req_cnt, 8);

      // B/C: current at neuron 3 persists; neuron 5 loaded with the start pulse.
      write_i(3'd3, 17'h00C00);
      run_step(0, '0, '0, 0);
      chk("B core_i[3]", z17(obs_i[3]), 32'h00C00);
      chk("B core_i[4]", z17(obs_i[4]), 0);
      run_step(1, 3'd5, 17'd17920, 0);
      chk("C core_i[3]", z17(obs_i[3]), 32'h00C00);
      chk("C core_i[5]", z17(obs_i[5]), 17920);
      chk("C spikes", spike_cnt, 1);
      chk("C spike addr", spike_seen_addr, 5);
      chk("C spike offset", spike_at - start_cyc, 30);

      // D: start and load pulses while busy must be ignored.
      run_step(0, '0, '0, 1);
      chk("D done offset", done_off, 41);
      chk("D req count", req_cnt, 8);

      // E: reset while waiting on neuron 4's result.
      @(posedge clk); #2;
      step_start = 1'b1;
      cnt = 0;
      for (int t = 0; t < 100 && cnt < 5; t++) begin
         @(posedge clk); #2;
         step_start = 1'b0;
         if (core_bus.core_req) cnt++;
      end
      chk("E dropped load core_i[0]", z17(obs_i[0]), 0);
      @(posedge clk); #2;
      syn_reset = 1'b1;
      @(posedge clk); #2;
      syn_reset = 1'b0;
      chk("E busy after reset", busy, 0);
      chk("E core_v after reset", z17(core_bus.core_v), 0);
      repeat (4) @(posedge clk);

      // F: memories are back at resting values.
      run_step(0, '0, '0, 0);
      chk("F core_v[0]", z17(obs_v[0]), z17(-17'sd16640));
      chk("F core_i[3]", z17(obs_i[3]), 0);
      chk("F core_i[5]", z17(obs_i[5]), 0);
      chk("F spikes", spike_cnt, 0);
      chk("F done offset", done_off, 41);

      // G: slow ack for neuron 0 plus a bogus ack in its ISSUE cycle.
      slow_next  = 1;
      early_next = 1;
      run_step(0, '0, '0, 0);
      chk("G done offset", done_off, 49);
      chk("G req count", req_cnt, 8);
      chk("G core_v[0]", z17(obs_v[0]), z17(-17'sd16384));
      chk("G spikes", spike_cnt, 0);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
